cond_status_unit: RTL



---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_eval.sv | 45 ++++
 rtl/cond_status_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the condition/status unit: condition code values,
// NZCV flag bit positions and the predication-state field widths.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int IT_COND_W  = 4;
    localparam int IT_MASK_W  = 4;
    localparam int IT_STATE_W = IT_COND_W + IT_MASK_W;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of one 4-bit condition code against NZCV flags.
// Every code, including NV, resolves to a defined 0/1.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] code,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Decode the condition code into its pass/fail result.
    always_comb begin
        pass = 1'b0;
        case (code)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_status_unit.sv
// NZCV status register with same-cycle write forwarding, NUM_CH parallel
// condition lanes, and an IT-style predication sequencer driving lane 0.
module cond_status_unit
    import cond_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter bit REG_OUT = 1'b1,
    parameter bit IT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  status_we,
    input  logic [3:0]            status_in,
    output logic [3:0]            status_q,
    input  logic [4*NUM_CH-1:0]   cond_in,
    input  logic [NUM_CH-1:0]     cond_valid_in,
    output logic [NUM_CH-1:0]     cond_out,
    output logic [NUM_CH-1:0]     cond_valid_out,
    input  logic                  it_start,
    input  logic [3:0]            it_firstcond,
    input  logic [3:0]            it_mask,
    input  logic                  it_adv,
    output logic                  it_active,
    output logic [3:0]            it_cond,
    output logic                  it_err
);

    logic [3:0]        status_d;
    logic [3:0]        eval_flags;
    logic [3:0]        lane_code [NUM_CH];
    logic [NUM_CH-1:0] lane_pass;
    logic [NUM_CH-1:0] cond_out_d;
    logic [NUM_CH-1:0] cond_valid_out_d;

    // Next status value and the flags lanes see: a write in flight wins.
    always_comb begin
        status_d   = status_we ? status_in : status_q;
        eval_flags = status_d;
    end

    // Architectural status register.
    always_ff @(posedge clk) begin
        if (rst) status_q <= 4'b0000;
        else     status_q <= status_d;
    end

    generate
        if (IT_EN) begin : g_it
            logic [IT_STATE_W-1:0] itstate_d;
            logic [IT_STATE_W-1:0] itstate_q;
            logic                  it_err_d;
            logic                  it_err_q;
            logic                  active_now;

            assign active_now = (itstate_q[IT_MASK_W-1:0] != '0);

            // Sequencer next state: advance consumes the block, starts only load when idle.
            always_comb begin
                itstate_d = itstate_q;
                it_err_d  = 1'b0;
                if (active_now) begin
                    if (it_adv) begin
                        if (itstate_q[2:0] == 3'b000) itstate_d = '0;
                        else itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
                    end
                    if (it_start) it_err_d = 1'b1;
                end else if (it_start) begin
                    if (it_mask != 4'b0000) itstate_d = {it_firstcond, it_mask};
                    else                    it_err_d  = 1'b1;
                end
            end

            // Predication state and error pulse registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    itstate_q <= '0;
                    it_err_q  <= 1'b0;
                end else begin
                    itstate_q <= itstate_d;
                    it_err_q  <= it_err_d;
                end
            end

            assign it_active = active_now;
            assign it_cond   = itstate_q[IT_STATE_W-1 -: IT_COND_W];
            assign it_err    = it_err_q;
        end else begin : g_no_it
            assign it_active = 1'b0;
            assign it_cond   = COND_AL;
            assign it_err    = 1'b0;
        end
    endgenerate

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lane
            if (g == 0) begin : g_lane0
                assign lane_code[g] = (IT_EN && it_active) ? it_cond : cond_in[3:0];
            end else begin : g_lanen
                assign lane_code[g] = cond_in[4*g +: 4];
            end
            cond_eval u_eval (
                .code  (lane_code[g]),
                .flags (eval_flags),
                .pass  (lane_pass[g])
            );
        end
    endgenerate

    // Lane results are suppressed for lanes without a request.
    always_comb begin
        cond_out_d       = lane_pass & cond_valid_in;
        cond_valid_out_d = cond_valid_in;
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [NUM_CH-1:0] cond_out_q;
            logic [NUM_CH-1:0] cond_valid_out_q;

            // One-cycle output stage capturing the request-cycle result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cond_out_q       <= '0;
                    cond_valid_out_q <= '0;
                end else begin
                    cond_out_q       <= cond_out_d;
                    cond_valid_out_q <= cond_valid_out_d;
                end
            end

            assign cond_out       = cond_out_q;
            assign cond_valid_out = cond_valid_out_q;
        end else begin : g_comb_out
            assign cond_out       = cond_out_d;
            assign cond_valid_out = cond_valid_out_d;
        end
    endgenerate

endmodule
